// File: rtl/coeff_loader_if.sv
// Coefficient load stream plus the committed coefficient-set outputs.
interface coeff_loader_if #(
   parameter int NBITS = 11,
   parameter int N     = 32
);
   logic                   start;
   logic [2*NBITS-1:0]     s_data;
   logic                   s_valid;
   logic                   s_last;
   logic                   s_ready;
   logic [NBITS*N*2-1:0]   coeff_data;
   logic                   coeff_valid;
   logic                   load_done;
   logic                   len_err;
   logic                   busy;

   modport master (
      output start, s_data, s_valid, s_last,
      input  s_ready, coeff_data, coeff_valid, load_done, len_err, busy
   );

   modport slave (
      input  start, s_data, s_valid, s_last,
      output s_ready, coeff_data, coeff_valid, load_done, len_err, busy
   );
endinterface

// File: rtl/coeff_loader.sv
// Twiddle-coefficient writer: collects one complex word per beat into a
// shadow bank and swaps the whole bank onto coeff_data only after a frame
// of exactly N beats, so butterflies never see a half-written set.
module coeff_loader #(
   parameter int NBITS = 11,
   parameter int N     = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   coeff_loader_if.slave bus
);
   localparam int W  = 2 * NBITS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         wr_idx_q, wr_idx_d;
   logic [IW-1:0]         wr_slot;
   logic                  wr_en, abort, accept, last_idx;
   // Entry k lives in packed slot N-1-k so entry 0 lands on the MSBs.
   logic [N-1:0][W-1:0]   shadow_q, coeff_q;
   logic                  coeff_valid_q, load_done_q, len_err_q;

   assign accept   = bus.s_valid && (state_q == LOAD);
   assign last_idx = (wr_idx_q == IW'(N-1));
   assign wr_slot  = IW'(N-1) - wr_idx_q;

   // Next-state: start restarts a load (beats in that cycle are dropped);
   // length mismatches abort back to IDLE and flag an error.
   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      wr_en    = 1'b0;
      abort    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = LOAD;
               wr_idx_d = '0;
            end
         end
         LOAD: begin
            if (bus.start) begin
               wr_idx_d = '0;
            end else if (accept) begin
               wr_en = 1'b1;
               if (last_idx) begin
                  if (bus.s_last) begin
                     state_d = COMMIT;
                  end else begin
                     state_d = IDLE;
                     abort   = 1'b1;
                  end
               end else if (bus.s_last) begin
                  state_d = IDLE;
                  abort   = 1'b1;
               end else begin
                  wr_idx_d = wr_idx_q + IW'(1);
               end
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and write-index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
      end
   end

   // Shadow bank captures accepted beats unmodified.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (wr_en) begin
         shadow_q[wr_slot] <= bus.s_data;
      end
   end

   // Active set swaps in whole during the single COMMIT cycle; status pulses
   // are registered so they line up with the new coeff_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coeff_q       <= '0;
         coeff_valid_q <= 1'b0;
         load_done_q   <= 1'b0;
         len_err_q     <= 1'b0;
      end else begin
         load_done_q <= (state_q == COMMIT);
         len_err_q   <= abort;
         if (state_q == COMMIT) begin
            coeff_q       <= shadow_q;
            coeff_valid_q <= 1'b1;
         end
      end
   end

   assign bus.s_ready     = (state_q == LOAD);
   assign bus.busy        = (state_q != IDLE);
   assign bus.coeff_data  = coeff_q;
   assign bus.coeff_valid = coeff_valid_q;
   assign bus.load_done   = load_done_q;
   assign bus.len_err     = len_err_q;
endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader at N=4, NBITS=11.
module tb_coeff_loader;
   localparam int NBITS = 11;
   localparam int N     = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   coeff_loader_if #(.NBITS(NBITS), .N(N)) bus ();

   coeff_loader #(.NBITS(NBITS), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Frame A: re = k+1, im = -(k+1); frame B: re = 100+k, im = 200+k.
   logic [21:0] fa [4] = '{{11'h001, 11'h7FF}, {11'h002, 11'h7FE},
                           {11'h003, 11'h7FD}, {11'h004, 11'h7FC}};
   logic [21:0] fb [4] = '{{11'h100, 11'h200}, {11'h101, 11'h201},
                           {11'h102, 11'h202}, {11'h103, 11'h203}};
   logic [87:0] exp_a = {11'h001, 11'h7FF, 11'h002, 11'h7FE,
                         11'h003, 11'h7FD, 11'h004, 11'h7FC};
   logic [87:0] exp_b = {11'h100, 11'h200, 11'h101, 11'h201,
                         11'h102, 11'h202, 11'h103, 11'h203};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic beat(input logic [21:0] d, input logic last);
      chk("s_ready_before_beat", bus.s_ready, 1'b1);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = 22'h3FFFFF;
   endtask

   task automatic frame(input logic [21:0] f [4]);
      for (int k = 0; k < 4; k++) beat(f[k], k == 3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = '0;
      #12;
      // Reset state
      chk("rst_coeff_data", bus.coeff_data, 88'h0);
      chk("rst_coeff_valid", bus.coeff_valid, 1'b0);
      chk("rst_load_done", bus.load_done, 1'b0);
      chk("rst_len_err", bus.len_err, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_s_ready", bus.s_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Nominal load, with latency check
      pulse_start();
      chk("nom_busy", bus.busy, 1'b1);
      for (int k = 0; k < 3; k++) beat(fa[k], 1'b0);
      beat(fa[3], 1'b1);
      chk("nom_data_before_commit", bus.coeff_data, 88'h0);
      chk("nom_done_before_commit", bus.load_done, 1'b0);
      tick();
      chk("nom_coeff_data", bus.coeff_data, exp_a);
      chk("nom_load_done", bus.load_done, 1'b1);
      chk("nom_coeff_valid", bus.coeff_valid, 1'b1);
      chk("nom_s_ready", bus.s_ready, 1'b0);
      tick();
      chk("nom_load_done_drop", bus.load_done, 1'b0);

      // Backpressure: valid pattern 1,0,0,1,1,0,1; idle cycles carry junk with s_last
      pulse_start();
      begin
         logic [6:0] pat;
         int         k;
         pat = 7'b1011001;   // bit 0 applied first
         k = 0;
         for (int c = 0; c < 7; c++) begin
            if (pat[c]) begin
               beat(fa[k], k == 3);
               k++;
            end else begin
               bus.s_valid = 1'b0;
               bus.s_last  = 1'b1;
               bus.s_data  = 22'h2AAAAA;
               tick();
               bus.s_last  = 1'b0;
            end
         end
      end
      tick();
      chk("bp_coeff_data", bus.coeff_data, exp_a);
      chk("bp_load_done", bus.load_done, 1'b1);
      tick();

      // Short frame: s_last on beat 1
      pulse_start();
      beat(22'h155555, 1'b0);
      beat(22'h155555, 1'b1);
      chk("short_len_err", bus.len_err, 1'b1);
      chk("short_busy", bus.busy, 1'b0);
      chk("short_load_done", bus.load_done, 1'b0);
      tick();
      chk("short_len_err_drop", bus.len_err, 1'b0);
      chk("short_coeff_kept", bus.coeff_data, exp_a);
      chk("short_coeff_valid", bus.coeff_valid, 1'b1);

      // Long frame: beat 3 without s_last, then a legal frame B
      pulse_start();
      for (int k = 0; k < 4; k++) beat(22'h0F0F0F, 1'b0);
      chk("long_len_err", bus.len_err, 1'b1);
      chk("long_busy", bus.busy, 1'b0);
      chk("long_coeff_kept", bus.coeff_data, exp_a);
      pulse_start();
      chk("long_len_err_drop", bus.len_err, 1'b0);
      frame(fb);
      tick();
      chk("long_then_legal", bus.coeff_data, exp_b);
      chk("long_then_done", bus.load_done, 1'b1);

      // Restart: start on the load_done cycle, abandon mid-frame, reload A
      pulse_start();
      beat(22'h3ABCDE, 1'b0);
      beat(22'h1234AB, 1'b0);
      bus.start   = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 22'h3C3C3C;
      tick();
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      chk("restart_len_err", bus.len_err, 1'b0);
      chk("restart_busy", bus.busy, 1'b1);
      frame(fa);
      bus.start = 1'b1;           // issued during COMMIT, must be ignored
      tick();
      bus.start = 1'b0;
      chk("restart_coeff_data", bus.coeff_data, exp_a);
      chk("restart_load_done", bus.load_done, 1'b1);
      chk("restart_no_len_err", bus.len_err, 1'b0);
      chk("commit_start_ignored", bus.busy, 1'b0);
      tick();

      // Async reset mid-LOAD, between edges
      pulse_start();
      beat(fb[0], 1'b0);
      beat(fb[1], 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_coeff_data", bus.coeff_data, 88'h0);
      chk("arst_coeff_valid", bus.coeff_valid, 1'b0);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_s_ready", bus.s_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      pulse_start();
      frame(fb);
      tick();
      chk("arst_reload_data", bus.coeff_data, exp_b);
      chk("arst_reload_valid", bus.coeff_valid, 1'b1);
      chk("arst_reload_done", bus.load_done, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Writer side of the twiddle-coefficient bus consumed by the FFT butterfly stages.
- Accepts complex coefficients one word per beat over a valid/ready stream and assembles them in a shadow bank.
- Atomically commits the shadow bank to the packed coeff_data output after a complete, length-checked frame.
- Lets the runtime reload the coefficient set that the constant tables otherwise fix at elaboration.

Parameters:
- NBITS, 11, width of each real and imaginary component (two's complement).
- N, 32, number of complex coefficients per set.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins (or restarts) a frame load.
- s_data  input  2*NBITS  coefficient word; [2*NBITS-1:NBITS] = real, [NBITS-1:0] = imaginary.
- s_valid  input  1  s_data is valid.
- s_last  input  1  marks the final beat of the frame.
- s_ready  output  1  loader accepts a beat this cycle.
- coeff_data  output  NBITS*N*2  active coefficient set; entry k occupies [2*NBITS*(N-k)-1 : 2*NBITS*(N-k-1)], so entry 0 sits at the MSBs; real in the upper half.
- coeff_valid  output  1  set after the first successful commit.
- load_done  output  1  one-cycle pulse on the cycle coeff_data takes a new set.
- len_err  output  1  one-cycle pulse when a frame aborts on a length mismatch.
- busy  output  1  state != IDLE.

Behaviour:
- Asynchronous reset (rst_n = 0) forces:
  - state = IDLE, wr_idx = 0, shadow = 0, coeff_data = 0;
  - coeff_valid = 0, load_done = 0, len_err = 0.
  - Reset mid-frame discards the frame.
- States: IDLE, LOAD, COMMIT.
- s_ready = (state == LOAD), decoded from registered state; no combinational path from s_valid.
- A beat is accepted when s_valid && s_ready.
- IDLE:
  - start -> LOAD, wr_idx <= 0.
  - s_valid is ignored (s_ready = 0).
- LOAD, accepted beat: shadow[wr_idx] <= s_data, then:
  - wr_idx == N-1 and s_last = 1 -> COMMIT.
  - wr_idx < N-1 and s_last = 0 -> wr_idx <= wr_idx + 1.
  - wr_idx < N-1 and s_last = 1 (short frame) -> IDLE; len_err pulses next cycle; coeff_data unchanged.
  - wr_idx == N-1 and s_last = 0 (long frame) -> IDLE; len_err pulses next cycle; coeff_data unchanged.
- LOAD, start asserted: restart, wr_idx <= 0, no error.
  - start has priority over a beat accepted in the same cycle; that beat is dropped.
  - Shadow contents are left stale; every entry is rewritten before a legal commit.
- COMMIT (exactly one cycle):
  - coeff_data <= shadow, with the final beat already in place.
  - Registered outputs then show coeff_valid <= 1 and load_done = 1 in the following cycle.
  - Next state IDLE; start in COMMIT is ignored.
- Latency: last beat accepted at edge E -> coeff_data updated and load_done high after edge E+1.
- Minimum frame-to-frame gap: start may be issued the cycle load_done is high.
- coeff_data changes only at a commit edge, never partially; consumers see either the old set or the new set.
- wr_idx width = clog2(N), minimum 1; no wrap past N-1 (the long-frame check aborts first).
- s_data is stored unmodified: no saturation or sign handling.
- load_done and len_err are never high together.

Test Plan:
- Nominal load (N=4, NBITS=11): reset, start, 4 beats of {re = k+1, im = -(k+1)} with s_last on beat 3 -> after edge E+1:
  - coeff_data = {001,7FF, 002,7FE, 003,7FD, 004,7FC} (11-bit hex fields);
  - load_done high exactly one cycle; coeff_valid = 1; s_ready = 0.
- Backpressure/gaps: same frame with s_valid toggling 1,0,0,1,1,0,1 -> identical coeff_data; wr_idx advances only on accepted beats.
- Short frame: s_last on beat 1 (N=4) -> len_err one cycle, state IDLE, coeff_data retains the previous set, coeff_valid unchanged.
- Long frame: beat 3 with s_last = 0 -> len_err; a following start plus a legal 4-beat frame commits normally.
- Restart: start during beat 2 of a frame, then a full new frame -> only the new frame values appear; no len_err.
- Async reset: assert rst_n = 0 mid-LOAD, between clock edges -> outputs zero immediately; the next start loads cleanly.
